// File: rtl/high_score_scanner_pkg.sv
// Shared constants, score type and scanner state encoding for the high-score read path.
// Optional index tracking is enabled with HIGH_SCORE_INDEX_EN.
package high_score_scanner_pkg;

  localparam int unsigned SCORE_W      = 11;
  localparam int unsigned SCORE_DEPTH  = 32;
  localparam int unsigned SCORE_ADDR_W = 5;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/high_score_scanner_top3_insert.sv
// Registered top-3 insertion sorter; strict-greater compares keep earlier entries on ties.
// With HIGH_SCORE_INDEX_EN the source index of each slot shifts alongside its value.
module top3_insert #(
  parameter int unsigned SCORE_W = high_score_scanner_pkg::SCORE_W
`ifdef HIGH_SCORE_INDEX_EN
  , parameter int unsigned ADDR_W = high_score_scanner_pkg::SCORE_ADDR_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [SCORE_W-1:0] in_value,
`ifdef HIGH_SCORE_INDEX_EN
  input  logic [ADDR_W-1:0]  in_index,
  output logic [ADDR_W-1:0]  wi0,
  output logic [ADDR_W-1:0]  wi1,
  output logic [ADDR_W-1:0]  wi2,
`endif
  output logic [SCORE_W-1:0] w0,
  output logic [SCORE_W-1:0] w1,
  output logic [SCORE_W-1:0] w2
);
  import high_score_scanner_pkg::*;

  logic beat0;
  logic beat1;
  logic beat2;

  assign beat0 = in_value > w0;
  assign beat1 = in_value > w1;
  assign beat2 = in_value > w2;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (in_valid) begin
      if (beat0) begin
        w2 <= w1;
        w1 <= w0;
        w0 <= in_value;
      end else if (beat1) begin
        w2 <= w1;
        w1 <= in_value;
      end else if (beat2) begin
        w2 <= in_value;
      end
    end
  end

`ifdef HIGH_SCORE_INDEX_EN
  // Index slots follow exactly the same shift decisions as the value slots.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wi0 <= '0;
      wi1 <= '0;
      wi2 <= '0;
    end else if (in_valid) begin
      if (beat0) begin
        wi2 <= wi1;
        wi1 <= wi0;
        wi0 <= in_index;
      end else if (beat1) begin
        wi2 <= wi1;
        wi1 <= in_index;
      end else if (beat2) begin
        wi2 <= in_index;
      end
    end
  end
`endif

endmodule

// File: rtl/high_score_scanner.sv
// Walks the score RAM read port, sorts returns through top3_insert and publishes the top 3.
// Define HIGH_SCORE_INDEX_EN to also publish the RAM address of each top score.
module high_score_scanner #(
  parameter int unsigned DEPTH      = high_score_scanner_pkg::SCORE_DEPTH,
  parameter int unsigned ADDR_W     = high_score_scanner_pkg::SCORE_ADDR_W,
  parameter int unsigned SCORE_W    = high_score_scanner_pkg::SCORE_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SCORE_W-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] top0,
  output logic [SCORE_W-1:0] top1,
  output logic [SCORE_W-1:0] top2
`ifdef HIGH_SCORE_INDEX_EN
  ,
  output logic [ADDR_W-1:0]  idx0,
  output logic [ADDR_W-1:0]  idx1,
  output logic [ADDR_W-1:0]  idx2
`endif
);
  import high_score_scanner_pkg::*;

  localparam logic [RD_LATENCY-1:0] TAP_BIT = RD_LATENCY'(1) << (RD_LATENCY - 1);

  scan_state_t              state;
  logic [RD_LATENCY-1:0]    validPipe;
  logic                     clearW;
  logic                     consume;
  logic                     lastAddr;
  logic                     drained;
  logic [SCORE_W-1:0]       w0;
  logic [SCORE_W-1:0]       w1;
  logic [SCORE_W-1:0]       w2;

  assign clearW   = (state == IDLE) && start;
  assign consume  = validPipe[RD_LATENCY-1];
  assign lastAddr = rd_addr == ADDR_W'(DEPTH - 1);
  // Only the return leaving the pipe this edge may still be outstanding.
  assign drained  = (validPipe & ~TAP_BIT) == '0;

`ifdef HIGH_SCORE_INDEX_EN
  logic [ADDR_W-1:0] capIdx;
  logic [ADDR_W-1:0] wi0;
  logic [ADDR_W-1:0] wi1;
  logic [ADDR_W-1:0] wi2;

  // Returns arrive in address order, so a counter of consumed beats is the source address.
  always_ff @(posedge clk) begin
    if (!reset || clearW) begin
      capIdx <= '0;
    end else if (consume) begin
      capIdx <= capIdx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx0 <= '0;
      idx1 <= '0;
      idx2 <= '0;
    end else if (state == PUBLISH) begin
      idx0 <= wi0;
      idx1 <= wi1;
      idx2 <= wi2;
    end
  end
`endif

  top3_insert #(
    .SCORE_W (SCORE_W)
`ifdef HIGH_SCORE_INDEX_EN
    , .ADDR_W (ADDR_W)
`endif
  ) u_sort (
    .clk      (clk),
    .reset    (reset),
    .clear    (clearW),
    .in_valid (consume),
    .in_value (rd_data),
`ifdef HIGH_SCORE_INDEX_EN
    .in_index (capIdx),
    .wi0      (wi0),
    .wi1      (wi1),
    .wi2      (wi2),
`endif
    .w0       (w0),
    .w1       (w1),
    .w2       (w2)
  );

  // Scan sequencer: issue every address, drain in-flight reads, publish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      top0      <= '0;
      top1      <= '0;
      top2      <= '0;
      validPipe <= '0;
    end else begin
      validPipe <= (validPipe << 1) | RD_LATENCY'(rd_en);
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        ISSUE: begin
          if (lastAddr) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= PUBLISH;
          end
        end
        PUBLISH: begin
          state <= IDLE;
          done  <= 1'b1;
          top0  <= w0;
          top1  <= w1;
          top2  <= w2;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_high_score_scanner.sv
// Self-checking bench for high_score_scanner: RAM models at read latency 1 and 2,
// vector table plus scoreboard of expected publishes; honours HIGH_SCORE_INDEX_EN.
module tb_high_score_scanner;

  localparam int unsigned AW    = 5;
  localparam int unsigned SW    = 11;
  localparam int unsigned DEP   = 32;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 2;
  localparam int unsigned NVEC  = 5;

  typedef struct packed {
    logic [SW-1:0] t0, t1, t2;
    logic [AW-1:0] i0, i1, i2;
    logic [31:0]   doneAt;
  } exp_t;

  typedef struct packed {
    logic [4:0][AW-1:0] a;
    logic [4:0][SW-1:0] v;
    logic [2:0][SW-1:0] t;
    logic [2:0][AW-1:0] i;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          startA = 1'b0, startB = 1'b0;
  logic          rdEnA, rdEnB, busyA, busyB, doneA, doneB;
  logic [AW-1:0] rdAddrA, rdAddrB;
  logic [SW-1:0] rdDataA = '0, rdDataB = '0, stageB = '0;
  logic [SW-1:0] top0A, top1A, top2A, top0B, top1B, top2B;
`ifdef HIGH_SCORE_INDEX_EN
  logic [AW-1:0] idx0A, idx1A, idx2A, idx0B, idx1B, idx2B;
`endif

  logic [SW-1:0] ramA [DEP];
  logic [SW-1:0] ramB [DEP];

  always @(posedge clk) if (rdEnA) rdDataA <= ramA[rdAddrA];
  always @(posedge clk) begin
    if (rdEnB) stageB <= ramB[rdAddrB];
    rdDataB <= stageB;
  end

  high_score_scanner #(.RD_LATENCY(LAT_A)) dutA (
    .clk(clk), .reset(reset), .start(startA), .rd_en(rdEnA), .rd_addr(rdAddrA),
    .rd_data(rdDataA), .busy(busyA), .done(doneA), .top0(top0A), .top1(top1A), .top2(top2A)
`ifdef HIGH_SCORE_INDEX_EN
    , .idx0(idx0A), .idx1(idx1A), .idx2(idx2A)
`endif
  );

  high_score_scanner #(.RD_LATENCY(LAT_B)) dutB (
    .clk(clk), .reset(reset), .start(startB), .rd_en(rdEnB), .rd_addr(rdAddrB),
    .rd_data(rdDataB), .busy(busyB), .done(doneB), .top0(top0B), .top1(top1B), .top2(top2B)
`ifdef HIGH_SCORE_INDEX_EN
    , .idx0(idx0B), .idx1(idx1B), .idx2(idx2B)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   donesA = 0, donesB = 0, doneAtB = 0;
  int   sweepCnt = 0, sweepBad = 0;
  exp_t expQ[$];
  exp_t popE;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: advance to the falling edge and observe both DUTs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!reset) begin
      sweepCnt = 0;
      sweepBad = 0;
    end
    if (rdEnA) begin
      if (rdAddrA !== AW'(sweepCnt)) sweepBad++;
      sweepCnt++;
    end
    if (doneA) begin
      donesA++;
      if (expQ.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        popE = expQ.pop_front();
        check("done_cycle", cyc, popE.doneAt);
        check("busy_at_done", 32'(busyA), 32'd1);
        check("top0", 32'(top0A), 32'(popE.t0));
        check("top1", 32'(top1A), 32'(popE.t1));
        check("top2", 32'(top2A), 32'(popE.t2));
`ifdef HIGH_SCORE_INDEX_EN
        check("idx0", 32'(idx0A), 32'(popE.i0));
        check("idx1", 32'(idx1A), 32'(popE.i1));
        check("idx2", 32'(idx2A), 32'(popE.i2));
`endif
        check("sweep_count", sweepCnt, DEP);
        check("sweep_order", sweepBad, 0);
      end
      sweepCnt = 0;
      sweepBad = 0;
    end
    if (doneB) begin
      donesB++;
      doneAtB = cyc;
    end
  endtask

  // Scan on dutA; retrig>0 pulses start again at that busy cycle.
  task automatic scanA(input exp_t e, input int retrig);
    exp_t x;
    int   k;
    x        = e;
    x.doneAt = 32'(cyc + 1 + int'(DEP) + int'(LAT_A) + 1);
    expQ.push_back(x);
    startA = 1'b1;
    tick();
    startA = 1'b0;
    k = 1;
    while (expQ.size() != 0 && k < 200) begin
      startA = (k == retrig);
      tick();
      k++;
    end
    startA = 1'b0;
    if (expQ.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      expQ.delete();
    end else begin
      tick();
      check("busy_after_done", 32'(busyA), 32'd0);
      check("done_one_cycle", 32'(doneA), 32'd0);
    end
  endtask

  // Reference: repeated max selection, lowest address wins ties, empty slot index is 0.
  function automatic exp_t modelA();
    exp_t r;
    logic taken [DEP];
    logic [SW-1:0] bv [3];
    logic [AW-1:0] bi [3];
    int   best;
    for (int a = 0; a < int'(DEP); a++) taken[a] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      best = -1;
      for (int a = 0; a < int'(DEP); a++)
        if (!taken[a] && (best < 0 || ramA[a] > ramA[best])) best = a;
      taken[best] = 1'b1;
      bv[s] = ramA[best];
      bi[s] = (ramA[best] == '0) ? '0 : AW'(best);
    end
    r = '0;
    r.t0 = bv[0]; r.t1 = bv[1]; r.t2 = bv[2];
    r.i0 = bi[0]; r.i1 = bi[1]; r.i2 = bi[2];
    return r;
  endfunction

  initial begin
    exp_t e;
    int   d0;
    int   tStart;

    vecs[0] = '{a: {5'd4, 5'd3, 5'd2, 5'd1, 5'd0},
                v: {11'd19, 11'd42, 11'd3, 11'd42, 11'd7},
                t: {11'd19, 11'd42, 11'd42}, i: {5'd4, 5'd3, 5'd1}};
    vecs[1] = '{a: {5'd0, 5'd0, 5'd0, 5'd0, 5'd9},
                v: {11'd0, 11'd0, 11'd0, 11'd0, 11'd100},
                t: {11'd0, 11'd0, 11'd100}, i: {5'd0, 5'd0, 5'd9}};
    vecs[2] = '{a: '0, v: '0, t: '0, i: '0};
    vecs[3] = '{a: {5'd0, 5'd20, 5'd6, 5'd2, 5'd0},
                v: {11'd0, 11'd5, 11'd5, 11'd5, 11'd4},
                t: {11'd5, 11'd5, 11'd5}, i: {5'd20, 5'd6, 5'd2}};
    vecs[4] = '{a: {5'd31, 5'd30, 5'd29, 5'd3, 5'd0},
                v: {11'd31, 11'd30, 11'd29, 11'd28, 11'd2047},
                t: {11'd30, 11'd31, 11'd2047}, i: {5'd30, 5'd31, 5'd0}};

    for (int k = 0; k < int'(DEP); k++) begin
      ramA[k] = '0;
      ramB[k] = '0;
    end

    // Reset held while start is pulsed: nothing may happen.
    reset  = 1'b0;
    startA = 1'b1;
    repeat (4) tick();
    check("rst_rd_en", 32'(rdEnA), 32'd0);
    check("rst_busy", 32'(busyA), 32'd0);
    check("rst_top0", 32'(top0A), 32'd0);
    check("rst_top1", 32'(top1A), 32'd0);
    check("rst_top2", 32'(top2A), 32'd0);
    startA = 1'b0;
    reset  = 1'b1;
    repeat (2) tick();
    check("rst_no_done", donesA, 0);

    // Table of RAM images with hand-derived top-3 results.
    for (int n = 0; n < int'(NVEC); n++) begin
      for (int k = 0; k < int'(DEP); k++) ramA[k] = '0;
      for (int p = 0; p < 5; p++)
        if (vecs[n].v[p] != '0) ramA[vecs[n].a[p]] = vecs[n].v[p];
      e = '0;
      e.t0 = vecs[n].t[0]; e.t1 = vecs[n].t[1]; e.t2 = vecs[n].t[2];
      e.i0 = vecs[n].i[0]; e.i1 = vecs[n].i[1]; e.i2 = vecs[n].i[2];
      scanA(e, 0);
      repeat (2) tick();
    end

    // Random images checked against the selection model.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < int'(DEP); k++)
        ramA[k] = (n == 0) ? SW'($urandom_range(0, 2047)) : SW'($urandom_range(0, 3));
      scanA(modelA(), 0);
      tick();
    end

    // Second start during the scan is ignored: exactly one publish.
    for (int k = 0; k < int'(DEP); k++) ramA[k] = '0;
    for (int p = 0; p < 5; p++) ramA[vecs[0].a[p]] = vecs[0].v[p];
    e = '0;
    e.t0 = 11'd42; e.t1 = 11'd42; e.t2 = 11'd19;
    e.i0 = 5'd1;   e.i1 = 5'd3;   e.i2 = 5'd4;
    d0 = donesA;
    scanA(e, 10);
    repeat (40) tick();
    check("single_done", donesA - d0, 1);

    // Reset at busy cycle 15 aborts the scan and clears the published scores.
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (14) tick();
    check("pre_abort_busy", 32'(busyA), 32'd1);
    d0 = donesA;
    reset = 1'b0;
    tick();
    check("abort_busy", 32'(busyA), 32'd0);
    check("abort_rd_en", 32'(rdEnA), 32'd0);
    check("abort_top0", 32'(top0A), 32'd0);
    check("abort_top1", 32'(top1A), 32'd0);
    check("abort_top2", 32'(top2A), 32'd0);
    reset = 1'b1;
    repeat (60) tick();
    check("abort_no_done", donesA - d0, 0);

    // Read latency 2 with the maximum score at the last address.
    ramB[0]  = 11'd1000;
    ramB[5]  = 11'd1500;
    ramB[31] = 11'd2047;
    d0 = donesB;
    tStart = cyc + 1;
    startB = 1'b1;
    tick();
    startB = 1'b0;
    for (int k = 0; k < 200 && donesB == d0; k++) tick();
    check("lat2_done_count", donesB - d0, 1);
    check("lat2_done_cycle", doneAtB, tStart + int'(DEP) + int'(LAT_B) + 1);
    check("lat2_top0", 32'(top0B), 32'd2047);
    check("lat2_top1", 32'(top1B), 32'd1500);
    check("lat2_top2", 32'(top2B), 32'd1000);
`ifdef HIGH_SCORE_INDEX_EN
    check("lat2_idx0", 32'(idx0B), 32'd31);
    check("lat2_idx1", 32'(idx1B), 32'd5);
    check("lat2_idx2", 32'(idx2B), 32'd0);
`endif
    tick();
    check("lat2_busy_after", 32'(busyB), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
